fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Instruction-fetch front end of the RV32I core.
- Owns the PC and drives the word address into the synchronous-read instruction memory, which returns data one cycle after the address.
- Pairs each returned word with its PC and presents it to decode over a valid/ready handshake.
- Absorbs decode back-pressure with an output register plus a one-entry skid buffer.
- Handles branch/jump redirects by flushing everything in flight.

Parameters:
- XLEN, 32, PC and instruction width.
- ADDR_W, 10, instruction-memory word-address width.
- RESET_PC, 32'h0000_0000, PC fetched first after reset.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- imem_addr  out  ADDR_W  word address to instruction memory; equals fetch_pc[ADDR_W+1:2], combinational from fetch_pc.
- imem_instr  in  XLEN  memory data for the address presented on the previous cycle.
- redirect_valid  in  1  taken branch/jump; flush and refetch.
- redirect_pc  in  XLEN  redirect target; bits [1:0] ignored.
- out_valid  out  1  out_instr/out_pc hold a valid fetched instruction.
- out_ready  in  1  decode accepts when out_valid && out_ready.
- out_instr  out  XLEN  fetched instruction.
- out_pc  out  XLEN  byte address of out_instr.

Behaviour:
- State:
  - fetch_pc: address currently presented.
  - resp_v, resp_pc: imem_instr this cycle belongs to resp_pc.
  - out register: out_valid, out_instr, out_pc.
  - skid register: skid_v, skid_instr, skid_pc.
- Reset (rst=1 at posedge):
  - fetch_pc<=RESET_PC.
  - resp_v, skid_v, out_valid <= 0.
  - out_instr, out_pc, skid contents <= 0.
  - While rst is high, imem_addr = RESET_PC word and no issue occurs.
  - rst mid-operation discards all in-flight and buffered instructions.
- pop = out_valid && out_ready.
- issue = !rst && !redirect_valid && !skid_v && !(out_valid && !out_ready && resp_v).
  - On issue: resp_v<=1, resp_pc<=fetch_pc, fetch_pc<=fetch_pc+4 (mod 2^32).
  - Otherwise: resp_v<=0 and fetch_pc holds, so imem_addr is stable.
- Out register update, when no redirect: if pop || !out_valid, out loads, in priority order:
  - skid, if skid_v; skid_v<=0;
  - else imem_instr/resp_pc, if resp_v;
  - else out_valid<=0.
  - Otherwise out holds.
- Skid update: if out holds and resp_v, skid <= {imem_instr, resp_pc} and skid_v<=1.
- Invariant: skid_v implies !resp_v. Bench asserts it every cycle.
- Redirect (redirect_valid=1) has priority over everything except rst:
  - fetch_pc <= {redirect_pc[31:2],2'b00}.
  - resp_v, skid_v, out_valid <= 0.
  - The current imem_instr is discarded.
  - A pop in the redirect cycle still completes: decode sees it accepted. Decode owns squashing it if needed.
- Latency:
  - First cycle with rst low = C0: imem_addr valid in C0, data in C1, out_valid in C2.
  - Redirect at cycle T: new address at T+1, out_valid with out_pc=target at T+3.
- Throughput: one instruction/cycle with out_ready held high. No duplicates or drops under any ready pattern.
- Wrap-around:
  - PC wraps at 2^32.
  - imem_addr wraps modulo 2^ADDR_W, with no bounds check; memory depth is software's responsibility.
  - out_pc reports the full 32-bit PC.

Decomposition:
- Shared package core_pkg:
  - XLEN.
  - RESET_PC default.
  - NOP_INSTR = 32'h0000_0013, for decode use.
  - Fetch packet struct {instr, pc}.
- One natural sub-module: fetch_skid_buf, the out register + skid register with valid/ready, load and flush inputs.
- PC/issue logic stays in fetch_stage.

Test Plan:
- Reset release, RESET_PC=0, out_ready=1, imem[i]=32'h100+i -> out_valid first high at C2; out_pc 0,4,8,... and out_instr 0x100,0x101,... every cycle.
- Mid-stream out_ready=0 for 3 cycles -> out holds one entry, skid captures the next, imem_addr frozen; on release the sequence continues contiguous with no gaps or duplicates; skid_v&&resp_v never seen.
- Redirect to 0x40 while out and skid both full -> both dropped the next cycle; out_pc=0x40 with instr=imem[16] exactly 3 cycles after redirect.
- Redirect to 0x46 -> imem_addr=0x11 next cycle, out_pc=0x44.
- rst asserted for one cycle while out_valid=1 and out_ready=0 -> out_valid=0 the next cycle; refetch from RESET_PC, out_valid 2 cycles after rst drops.
- Redirect to 0xFFC (ADDR_W=10) -> imem_addr 0x3FF then 0x000; out_pc 0xFFC then 0x1000.

Source files
------------

// File: rtl/core_pkg.sv
// Shared RV32I core types: datapath width, reset PC, NOP encoding and the fetch packet.
package core_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [XLEN-1:0] NOP_INSTR    = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetch_pkt_t;

  function automatic logic [XLEN-1:0] pc_align(input logic [XLEN-1:0] pc);
    return {pc[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// Output register plus one-entry skid for fetch packets; 1-cycle latency in to out.
// A held output diverts the arriving packet into the skid; flush empties both.
module fetch_skid_buf
  import core_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       i_flush,
  input  logic       i_in_vld,
  input  fetch_pkt_t i_in_dat,
  input  logic       i_out_rdy,
  output logic       o_out_vld,
  output fetch_pkt_t o_out_dat,
  output logic       o_skid_vld
);

  fetch_pkt_t r_out;
  fetch_pkt_t r_skid;
  logic       r_out_vld;
  logic       r_skid_vld;
  logic       w_load;

  assign w_load = !r_out_vld || i_out_rdy;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_vld  <= 1'b0;
      r_skid_vld <= 1'b0;
      r_out      <= '0;
      r_skid     <= '0;
    end else if (i_flush) begin
      r_out_vld  <= 1'b0;
      r_skid_vld <= 1'b0;
    end else if (w_load) begin
      // The skid is older than anything arriving, so it drains first.
      if (r_skid_vld) begin
        r_out      <= r_skid;
        r_out_vld  <= 1'b1;
        r_skid_vld <= 1'b0;
      end else if (i_in_vld) begin
        r_out     <= i_in_dat;
        r_out_vld <= 1'b1;
      end else begin
        r_out_vld <= 1'b0;
      end
    end else if (i_in_vld) begin
      r_skid     <= i_in_dat;
      r_skid_vld <= 1'b1;
    end
  end

  assign o_out_vld  = r_out_vld;
  assign o_out_dat  = r_out;
  assign o_skid_vld = r_skid_vld;

endmodule

// File: rtl/fetch_stage.sv
// RV32I fetch: PC owner driving a sync-read imem; address to out_valid is 2 cycles.
// Issue stalls while the skid is occupied or a held output would overflow it.
module fetch_stage
  import core_pkg::*;
#(
  parameter int              XLEN     = core_pkg::XLEN,
  parameter int              ADDR_W   = 10,
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [XLEN-1:0]   imem_instr,
  input  logic              redirect_valid,
  input  logic [XLEN-1:0]   redirect_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_instr,
  output logic [XLEN-1:0]   out_pc
);

  logic [XLEN-1:0] r_fetch_pc;
  logic [XLEN-1:0] r_resp_pc;
  logic            r_resp_v;

  logic            w_issue;
  logic            w_skid_v;
  logic            w_out_vld;
  fetch_pkt_t      w_resp_pkt;
  fetch_pkt_t      w_out_pkt;

  assign w_issue = !rst && !redirect_valid && !w_skid_v &&
                   !(w_out_vld && !out_ready && r_resp_v);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_pc <= RESET_PC;
      r_resp_v   <= 1'b0;
      r_resp_pc  <= '0;
    end else if (redirect_valid) begin
      r_fetch_pc <= pc_align(redirect_pc);
      r_resp_v   <= 1'b0;
    end else if (w_issue) begin
      r_resp_v   <= 1'b1;
      r_resp_pc  <= r_fetch_pc;
      r_fetch_pc <= r_fetch_pc + 32'd4;
    end else begin
      r_resp_v <= 1'b0;
    end
  end

  // Present the reset vector immediately so memory sees it while rst is held.
  assign imem_addr = rst ? RESET_PC[ADDR_W+1:2] : r_fetch_pc[ADDR_W+1:2];

  assign w_resp_pkt.instr = imem_instr;
  assign w_resp_pkt.pc    = r_resp_pc;

  fetch_skid_buf u_skid (
    .clk        (clk),
    .rst        (rst),
    .i_flush    (redirect_valid),
    .i_in_vld   (r_resp_v),
    .i_in_dat   (w_resp_pkt),
    .i_out_rdy  (out_ready),
    .o_out_vld  (w_out_vld),
    .o_out_dat  (w_out_pkt),
    .o_skid_vld (w_skid_v)
  );

  assign out_valid = w_out_vld;
  assign out_instr = w_out_pkt.instr;
  assign out_pc    = w_out_pkt.pc;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: stream model (next expected PC per accepted beat) plus directed latency pins.
module tb_fetch_stage;

  localparam int ADDR_W = 10;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              redirect_valid = 1'b0;
  logic [31:0]       redirect_pc = 32'h0;
  logic              out_ready = 1'b1;
  logic              out_valid;
  logic [31:0]       out_instr;
  logic [31:0]       out_pc;
  logic [31:0]       imem_instr;
  logic [ADDR_W-1:0] imem_addr;

  logic [31:0] mem [0:1023];
  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  initial for (int i = 0; i < 1024; i++) mem[i] = 32'h100 + i;

  always @(posedge clk) imem_instr <= mem[imem_addr];

  fetch_stage #(.XLEN(32), .ADDR_W(ADDR_W), .RESET_PC(32'h0)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_addr      (imem_addr),
    .imem_instr     (imem_instr),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] word_at(input logic [31:0] pc);
    return 32'h100 + {22'd0, pc[11:2]};
  endfunction

  task automatic go();
    @(posedge clk);
    #1;
  endtask

  // Stream model: every accepted beat must be the next PC after the last reset/redirect target.
  logic [31:0] m_pc;
  bit          m_hold;
  logic [31:0] h_pc, h_instr;
  int          idle;

  always @(negedge clk) begin
    if (rst) begin
      m_pc   = 32'h0;
      m_hold = 1'b0;
      idle   = 0;
    end else begin
      check("inv_skid_and_resp", {31'd0, dut.w_skid_v & dut.r_resp_v}, 32'd0);
      if (m_hold) begin
        check("hold_valid", {31'd0, out_valid}, 32'd1);
        check("hold_pc", out_pc, h_pc);
        check("hold_instr", out_instr, h_instr);
      end
      if (out_valid && out_ready) begin
        check("stream_pc", out_pc, m_pc);
        check("stream_instr", out_instr, word_at(m_pc));
        m_pc = m_pc + 32'd4;
        idle = 0;
      end else if (out_ready) begin
        idle++;
        if (idle == 8) check("stream_stall_cycles", idle, 32'd0);
      end
      if (redirect_valid) begin
        m_pc   = {redirect_pc[31:2], 2'b00};
        m_hold = 1'b0;
        idle   = 0;
      end else begin
        m_hold  = out_valid && !out_ready;
        h_pc    = out_pc;
        h_instr = out_instr;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  logic [47:0] pat;

  initial begin
    rst = 1'b1; out_ready = 1'b1;
    go(); go(); go();
    @(negedge clk);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_pc", out_pc, 32'd0);
    check("rst_out_instr", out_instr, 32'd0);
    check("rst_imem_addr", {22'd0, imem_addr}, 32'd0);

    // C0 / C1
    go(); rst = 1'b0;
    @(negedge clk);
    check("c0_valid", {31'd0, out_valid}, 32'd0);
    check("c0_addr", {22'd0, imem_addr}, 32'd0);
    go(); @(negedge clk);
    check("c1_valid", {31'd0, out_valid}, 32'd0);
    check("c1_addr", {22'd0, imem_addr}, 32'd1);
    // C2..C7 back-to-back
    for (int k = 0; k < 6; k++) begin
      go(); @(negedge clk);
      check("c2_stream_valid", {31'd0, out_valid}, 32'd1);
      check("c2_stream_pc", out_pc, 32'(4 * k));
      check("c2_stream_instr", out_instr, 32'h100 + k);
    end

    // C8..C10 stall
    go(); out_ready = 1'b0;
    @(negedge clk);
    check("stall_addr", {22'd0, imem_addr}, 32'd8);
    check("stall_pc", out_pc, 32'd24);
    for (int k = 0; k < 2; k++) begin
      go(); @(negedge clk);
      check("stall_addr", {22'd0, imem_addr}, 32'd8);
      check("stall_pc", out_pc, 32'd24);
      check("stall_skid_v", {31'd0, dut.w_skid_v}, 32'd1);
    end
    // C11..C14 release
    go(); out_ready = 1'b1;
    @(negedge clk); check("rel_pc0", out_pc, 32'd24);
    go(); @(negedge clk); check("rel_pc1", out_pc, 32'd28);
    go(); @(negedge clk); check("rel_bubble", {31'd0, out_valid}, 32'd0);
    go(); @(negedge clk);
    check("rel_pc2", out_pc, 32'd32);
    check("rel_instr2", out_instr, 32'h108);

    // C20: fill skid, C21: redirect with both buffers full
    repeat (6) go();
    out_ready = 1'b0;
    go(); redirect_valid = 1'b1; redirect_pc = 32'h40;
    @(negedge clk);
    check("rd40_pre_skid", {31'd0, dut.w_skid_v}, 32'd1);
    check("rd40_pre_out", {31'd0, out_valid}, 32'd1);
    go(); redirect_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    check("rd40_t1_valid", {31'd0, out_valid}, 32'd0);
    check("rd40_t1_skid", {31'd0, dut.w_skid_v}, 32'd0);
    check("rd40_t1_addr", {22'd0, imem_addr}, 32'h10);
    go(); @(negedge clk);
    check("rd40_t2_valid", {31'd0, out_valid}, 32'd0);
    go(); @(negedge clk);
    check("rd40_t3_valid", {31'd0, out_valid}, 32'd1);
    check("rd40_t3_pc", out_pc, 32'h40);
    check("rd40_t3_instr", out_instr, 32'h110);

    // C27: misaligned redirect
    repeat (3) go();
    redirect_valid = 1'b1; redirect_pc = 32'h46;
    go(); redirect_valid = 1'b0;
    @(negedge clk); check("rd46_addr", {22'd0, imem_addr}, 32'h11);
    go(); go(); @(negedge clk);
    check("rd46_pc", out_pc, 32'h44);
    check("rd46_instr", out_instr, 32'h111);

    // C32: hold, C33: one-cycle reset
    go(); go(); out_ready = 1'b0;
    go(); rst = 1'b1;
    @(negedge clk);
    check("mrst_out_held", {31'd0, out_valid}, 32'd1);
    check("mrst_addr", {22'd0, imem_addr}, 32'd0);
    go(); rst = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    check("mrst_c0_valid", {31'd0, out_valid}, 32'd0);
    check("mrst_c0_addr", {22'd0, imem_addr}, 32'd0);
    go(); @(negedge clk); check("mrst_c1_valid", {31'd0, out_valid}, 32'd0);
    go(); @(negedge clk);
    check("mrst_c2_valid", {31'd0, out_valid}, 32'd1);
    check("mrst_c2_pc", out_pc, 32'd0);
    check("mrst_c2_instr", out_instr, 32'h100);

    // C38: redirect to the top of memory
    go(); go(); redirect_valid = 1'b1; redirect_pc = 32'hFFC;
    go(); redirect_valid = 1'b0;
    @(negedge clk); check("wrap_addr0", {22'd0, imem_addr}, 32'h3FF);
    go(); @(negedge clk); check("wrap_addr1", {22'd0, imem_addr}, 32'h000);
    go(); @(negedge clk);
    check("wrap_pc0", out_pc, 32'hFFC);
    check("wrap_instr0", out_instr, 32'h4FF);
    go(); @(negedge clk);
    check("wrap_pc1", out_pc, 32'h1000);
    check("wrap_instr1", out_instr, 32'h100);

    // Irregular ready pattern, checked by the stream model only
    pat = 48'hA5C3_9F0E_6B21;
    for (int i = 0; i < 48; i++) begin
      go(); out_ready = pat[i];
    end
    go(); out_ready = 1'b1;
    repeat (10) go();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
